// File: rtl/i2c_state_pkg.sv
// Shared widths and idle levels for the I2C memory-side datapath.
package i2c_state_pkg;
  localparam int   BYTE_W      = 8;
  localparam int   BIT_CNT_W   = 3;
  localparam logic SDA_RELEASE = 1'b1;
endpackage

// File: rtl/i2c_byte_shifter.sv
// MSB-first byte shift register with bit counter, parallel load and a
// done pulse one cycle after the eighth shift.
module i2c_byte_shifter
  import i2c_state_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              shift,
  input  logic              fill,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_val,
  output logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] next_val,
  output logic              last,
  output logic              done
);
  logic [BIT_CNT_W-1:0] cnt;

  assign next_val = {data[BYTE_W-2:0], fill};
  assign last     = active & shift & (cnt == BIT_CNT_W'(BYTE_W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= RST_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (load)       data <= load_val;
      else if (shift) data <= next_val;
      // Dropping out of the active phase discards any partial byte count.
      if (!active)    cnt <= '0;
      else if (shift) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2c_mem_datapath.sv
// RAM-side I2C datapath: byte capture, auto-increment address, write strobe
// and read serialisation. Optional I2C_ADDR_SATURATE_EN holds the address at max.
module i2c_mem_datapath
  import i2c_state_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_rise,
  input  logic              scl_fall,
  input  logic              sda_in,
  input  logic              read_mem_address,
  input  logic              write_mem,
  input  logic              wren,
  input  logic              read_mem,
  input  logic              increment_mem_address,
  input  logic [7:0]        mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  output logic              sda_tx_bit,
  output logic              byte_rx_done,
  output logic              addr_ovf
);
  // RD_LAT must be >= 1; the counter loads RD_LAT and fires on reaching 1.
  localparam int CNT_W = $clog2(RD_LAT + 1);

  logic              capture;
  logic              rx_last;
  logic [BYTE_W-1:0] rx_data, rx_next;
  logic [BYTE_W-1:0] tx_data, unused_tx_next;
  logic              unused_tx_last, unused_tx_done;
  logic              tx_load, tx_shift;
  logic              wren_q, read_mem_q;
  logic [CNT_W-1:0]  rd_cnt;

  assign capture  = read_mem_address | write_mem;
  // A coincident rise wins; the fall is dropped.
  assign tx_shift = scl_fall & ~scl_rise & read_mem;
  assign tx_load  = (rd_cnt == CNT_W'(1));

  i2c_byte_shifter #(.RST_VAL('0)) u_rx (
    .clk(clk), .rst_n(rst_n), .active(capture), .shift(scl_rise & capture),
    .fill(sda_in), .load(1'b0), .load_val('0), .data(rx_data),
    .next_val(rx_next), .last(rx_last), .done(byte_rx_done)
  );

  i2c_byte_shifter #(.RST_VAL('1)) u_tx (
    .clk(clk), .rst_n(rst_n), .active(read_mem), .shift(tx_shift),
    .fill(SDA_RELEASE), .load(tx_load), .load_val(mem_q), .data(tx_data),
    .next_val(unused_tx_next), .last(unused_tx_last), .done(unused_tx_done)
  );

  assign sda_tx_bit = read_mem ? tx_data[BYTE_W-1] : SDA_RELEASE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      wren_q     <= 1'b0;
      read_mem_q <= 1'b0;
      rd_cnt     <= '0;
    end else begin
      wren_q     <= wren;
      mem_wren   <= wren & ~wren_q;
      read_mem_q <= read_mem;
      if (rx_last && write_mem) mem_data <= rx_next;
      if (read_mem && !read_mem_q) rd_cnt <= CNT_W'(RD_LAT);
      else if (rd_cnt != '0)       rd_cnt <= rd_cnt - 1'b1;
    end
  end

`ifdef I2C_ADDR_SATURATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      addr_ovf <= 1'b0;
    end else if (increment_mem_address) begin
      if (&mem_addr) addr_ovf <= 1'b1;
      else           mem_addr <= mem_addr + ADDR_W'(1);
    end else if (rx_last && read_mem_address) begin
      mem_addr <= rx_next[ADDR_W-1:0];
      addr_ovf <= 1'b0;
    end
  end
`else
  assign addr_ovf = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             mem_addr <= '0;
    else if (increment_mem_address)         mem_addr <= mem_addr + ADDR_W'(1);
    else if (rx_last && read_mem_address)   mem_addr <= rx_next[ADDR_W-1:0];
  end
`endif
endmodule
